// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   ALUOp / funct codes, forward-select codes, internal ALU op enum,
//   multiplier FSM states, ctrl bit positions, and the ALU-control decoder.
package ex_pkg;

    localparam int CTRL_W = 4;

    // ctrl_i / ctrl_o bit positions: {RegWrite, MemtoReg, MemWrite, MemRead}
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMREAD  = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    // 2'b11 falls back to the ID/EX value, same as 2'b00
    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_BUSY, ST_DONE
    } mul_state_e;

    function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_OR:  op = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_SLT: op = ALU_SLT;
                    FUNCT_MUL: op = ALU_MUL;
                    default:   op = ALU_ADD; // unknown funct executes as add
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, forwarding inputs and EX/MEM outputs of ex_stage.
//   slave  : the execute stage (consumes ID/EX, drives EX/MEM + stall_o)
//   master : the surrounding pipeline (drives ID/EX, observes EX/MEM)
interface ex_stage_if import ex_pkg::*; #(parameter int DATA_W = 32);
    logic [CTRL_W-1:0] ctrl_i;
    logic              ALUSrc_i;
    logic              RegDst_i;
    logic [1:0]        ALUOp_i;
    logic [5:0]        funct_i;
    logic [DATA_W-1:0] RSdata_i;
    logic [DATA_W-1:0] RTdata_i;
    logic [DATA_W-1:0] Sign_extend_i;
    logic [4:0]        RTaddr_i;
    logic [4:0]        RDaddr_i;
    logic [1:0]        fwdA_i;
    logic [1:0]        fwdB_i;
    logic [DATA_W-1:0] MEMfwd_i;
    logic [DATA_W-1:0] WBfwd_i;
    logic              flush_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] ALUresult_o;
    logic [DATA_W-1:0] WriteData_o;
    logic [4:0]        WRaddr_o;
    logic              stall_o;
    logic              overflow_o;

    modport slave (
        input  ctrl_i, ALUSrc_i, RegDst_i, ALUOp_i, funct_i, RSdata_i, RTdata_i,
               Sign_extend_i, RTaddr_i, RDaddr_i, fwdA_i, fwdB_i, MEMfwd_i, WBfwd_i, flush_i,
        output ctrl_o, ALUresult_o, WriteData_o, WRaddr_o, stall_o, overflow_o
    );

    modport master (
        output ctrl_i, ALUSrc_i, RegDst_i, ALUOp_i, funct_i, RSdata_i, RTdata_i,
               Sign_extend_i, RTaddr_i, RDaddr_i, fwdA_i, fwdB_i, MEMfwd_i, WBfwd_i, flush_i,
        input  ctrl_o, ALUresult_o, WriteData_o, WRaddr_o, stall_o, overflow_o
    );
endinterface

// File: rtl/ex_seq_mul.sv
// ex_seq_mul: iterative unsigned shift-add multiplier, low DATA_W bits of a*b.
//   start_i  : begin a multiply (honoured only in IDLE, ignored when flush_i)
//   flush_i  : abort from any state, back to IDLE with accumulator cleared
//   a_i, b_i : operands, latched on start
//   busy_o   : BUSY state; done_o : DONE state (product_o valid)
// Retires MUL_BITS_PER_CYCLE multiplier bits per BUSY cycle.
module ex_seq_mul import ex_pkg::*; #(
    parameter int DATA_W             = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);
    localparam int MUL_CYCLES = DATA_W / MUL_BITS_PER_CYCLE;
    localparam int CNT_W      = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_e        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] part;

    // Partial product for the low MUL_BITS_PER_CYCLE multiplier bits.
    always_comb begin
        part = '0;
        for (int j = 0; j < MUL_BITS_PER_CYCLE; j++)
            if (mplier_q[j]) part = part + (mcand_q << j);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                mcand_d  = a_i;
                mplier_d = b_i;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = ST_BUSY;
            end
            ST_BUSY: begin
                acc_d    = acc_q + part;
                mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
                mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_o    = (state_q == ST_BUSY);
    assign done_o    = (state_q == ST_DONE);
    assign product_o = acc_q;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Forwarding muxes, ALU control, ALU, iterative
// multiplier, and the EX/MEM pipeline register.
//   clk_i, rst_i : clock, async active-low reset
//   bus (slave)  : ID/EX fields, forwarding data, flush_i in;
//                  ctrl_o/ALUresult_o/WriteData_o/WRaddr_o/overflow_o/stall_o out
// Optional build macro EX_OVERFLOW_TRAP_EN: signed add/sub overflow sets
// overflow_o and clears RegWrite for that entry; otherwise overflow_o is 0.
module ex_stage import ex_pkg::*; #(
    parameter int DATA_W             = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    ex_stage_if.slave bus
);
    logic [DATA_W-1:0] op_a, b_fwd, op_b, alu_res, product;
    logic [4:0]        wr_sel;
    alu_op_e           alu_op;
    logic              mul_dec, mul_busy, mul_done, mul_idle, alu_ovf;

    logic [CTRL_W-1:0] ctrl_q, ctrl_d, mul_ctrl_q, mul_ctrl_d;
    logic [DATA_W-1:0] alu_q, alu_d, wd_q, wd_d;
    logic [4:0]        wr_q, wr_d, mul_wr_q, mul_wr_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        case (bus.fwdA_i)
            FWD_MEM: op_a = bus.MEMfwd_i;
            FWD_WB:  op_a = bus.WBfwd_i;
            default: op_a = bus.RSdata_i;
        endcase
        case (bus.fwdB_i)
            FWD_MEM: b_fwd = bus.MEMfwd_i;
            FWD_WB:  b_fwd = bus.WBfwd_i;
            default: b_fwd = bus.RTdata_i;
        endcase
        op_b   = bus.ALUSrc_i ? bus.Sign_extend_i : b_fwd;
        wr_sel = bus.RegDst_i ? bus.RDaddr_i : bus.RTaddr_i;
        alu_op = alu_decode(bus.ALUOp_i, bus.funct_i);
        mul_dec = (alu_op == ALU_MUL);
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = op_a + op_b; // ALU_MUL result comes from the multiplier
        endcase
    end

`ifdef EX_OVERFLOW_TRAP_EN
    logic ovf_chk;
    always_comb begin
        // Only explicit add/sub encodings trap; the unknown-funct add does not.
        ovf_chk = (bus.ALUOp_i == ALUOP_ADD) || (bus.ALUOp_i == ALUOP_SUB) ||
                  ((bus.ALUOp_i == ALUOP_RTYPE) &&
                   ((bus.funct_i == FUNCT_ADD) || (bus.funct_i == FUNCT_SUB)));
        if (alu_op == ALU_SUB)
            alu_ovf = ovf_chk && (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != op_a[DATA_W-1]);
        else
            alu_ovf = ovf_chk && (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != op_a[DATA_W-1]);
    end
`else
    always_comb alu_ovf = 1'b0;
`endif

    ex_seq_mul #(.DATA_W(DATA_W), .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_dec),
        .flush_i   (bus.flush_i),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (product)
    );
    assign mul_idle = !mul_busy && !mul_done;

    always_comb begin
        ctrl_d     = ctrl_q;
        alu_d      = alu_q;
        wd_d       = wd_q;
        wr_d       = wr_q;
        ovf_d      = ovf_q;
        mul_ctrl_d = mul_ctrl_q;
        mul_wr_d   = mul_wr_q;
        if (bus.flush_i) begin
            ctrl_d = '0;
            ovf_d  = 1'b0;
        end else if (mul_done) begin
            // ID/EX still shows the mul here; it is consumed, not restarted.
            ctrl_d = mul_ctrl_q;
            alu_d  = product;
            wr_d   = mul_wr_q;
            ovf_d  = 1'b0;
        end else if (mul_busy || mul_dec) begin
            ctrl_d = '0;
            ovf_d  = 1'b0;
            if (mul_idle) begin
                mul_ctrl_d = bus.ctrl_i;
                mul_wr_d   = wr_sel;
            end
        end else begin
            ctrl_d = bus.ctrl_i;
            if (alu_ovf) ctrl_d[CTRL_REGWRITE] = 1'b0;
            alu_d  = alu_res;
            wd_d   = b_fwd;
            wr_d   = wr_sel;
            ovf_d  = alu_ovf;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q     <= '0;
            alu_q      <= '0;
            wd_q       <= '0;
            wr_q       <= '0;
            ovf_q      <= 1'b0;
            mul_ctrl_q <= '0;
            mul_wr_q   <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            alu_q      <= alu_d;
            wd_q       <= wd_d;
            wr_q       <= wr_d;
            ovf_q      <= ovf_d;
            mul_ctrl_q <= mul_ctrl_d;
            mul_wr_q   <= mul_wr_d;
        end
    end

    // Gated by reset so every output reads 0 while rst_i is low.
    assign bus.stall_o     = rst_i && !bus.flush_i && (mul_busy || (mul_idle && mul_dec));
    assign bus.ctrl_o      = ctrl_q;
    assign bus.ALUresult_o = alu_q;
    assign bus.WriteData_o = wd_q;
    assign bus.WRaddr_o    = wr_q;
    assign bus.overflow_o  = ovf_q;
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    localparam int MBPC    = 1;
    localparam int MUL_CYC = 32 / MBPC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if #(.DATA_W(32)) bus();
    ex_stage #(.DATA_W(32), .MUL_BITS_PER_CYCLE(MBPC)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] ctrl, input logic alusrc, input logic regdst,
                             input logic [1:0] aluop, input logic [5:0] funct,
                             input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                             input logic [4:0] rta, input logic [4:0] rda,
                             input logic [1:0] fa, input logic [1:0] fb,
                             input logic [31:0] memf, input logic [31:0] wbf);
        bus.ctrl_i = ctrl; bus.ALUSrc_i = alusrc; bus.RegDst_i = regdst;
        bus.ALUOp_i = aluop; bus.funct_i = funct;
        bus.RSdata_i = rs; bus.RTdata_i = rt; bus.Sign_extend_i = imm;
        bus.RTaddr_i = rta; bus.RDaddr_i = rda;
        bus.fwdA_i = fa; bus.fwdB_i = fb;
        bus.MEMfwd_i = memf; bus.WBfwd_i = wbf;
        bus.flush_i = 1'b0;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                         input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'b10) return m;
        if (sel == 2'b01) return w;
        return r;
    endfunction

    function automatic logic oor(input longint s);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Reference ALU: arithmetic on 64-bit signed values, overflow by range test.
    task automatic ref_alu(input logic [1:0] aluop, input logic [5:0] funct,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic v);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        v = 1'b0;
        r = a + b;
        if (aluop == 2'b00) begin r = a + b; v = oor(sa + sb); end
        else if (aluop == 2'b01) begin r = a - b; v = oor(sa - sb); end
        else if (aluop == 2'b11) r = a | b;
        else begin
            case (funct)
                6'h20: begin r = a + b; v = oor(sa + sb); end
                6'h22: begin r = a - b; v = oor(sa - sb); end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
                default: r = a + b;
            endcase
        end
    endtask

    // One non-mul instruction: expect no stall, result one edge later.
    task automatic run_alu(input string tag);
        logic [31:0] a, bf, b, r;
        logic v;
        logic [3:0] ec;
        a  = pick(bus.fwdA_i, bus.RSdata_i, bus.MEMfwd_i, bus.WBfwd_i);
        bf = pick(bus.fwdB_i, bus.RTdata_i, bus.MEMfwd_i, bus.WBfwd_i);
        b  = bus.ALUSrc_i ? bus.Sign_extend_i : bf;
        ref_alu(bus.ALUOp_i, bus.funct_i, a, b, r, v);
        ec = bus.ctrl_i;
`ifdef EX_OVERFLOW_TRAP_EN
        if (v) ec[3] = 1'b0;
`else
        v = 1'b0;
`endif
        #1 chk({tag, ".stall"}, {31'd0, bus.stall_o}, 32'd0);
        tick();
        chk({tag, ".alu"},  bus.ALUresult_o, r);
        chk({tag, ".ctrl"}, {28'd0, bus.ctrl_o}, {28'd0, ec});
        chk({tag, ".wd"},   bus.WriteData_o, bf);
        chk({tag, ".wr"},   {27'd0, bus.WRaddr_o}, {27'd0, bus.RegDst_i ? bus.RDaddr_i : bus.RTaddr_i});
        chk({tag, ".ovf"},  {31'd0, bus.overflow_o}, {31'd0, v});
    endtask

    // Full multiply; forwarding data is scrambled while busy.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctrl, input logic [4:0] rd, input logic use_fwd);
        int stalls, bad;
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        if (use_fwd) set_instr(ctrl, 1'b0, 1'b1, 2'b10, 6'h18, $urandom, b, $urandom, 5'd1, rd,
                               2'b10, 2'b00, a, $urandom);
        else         set_instr(ctrl, 1'b0, 1'b1, 2'b10, 6'h18, a, b, $urandom, 5'd1, rd,
                               2'b00, 2'b00, $urandom, $urandom);
        stalls = 0; bad = 0;
        #1;
        for (int i = 0; i < 200; i++) begin
            if (!bus.stall_o) break;
            stalls++;
            tick();
            if (bus.ctrl_o !== 4'd0) bad++;
            bus.MEMfwd_i = $urandom;
            bus.WBfwd_i  = $urandom;
        end
        chk({tag, ".stalls"}, stalls, MUL_CYC + 1);
        chk({tag, ".bubbles"}, bad, 0);
        tick();
        chk({tag, ".prod"}, bus.ALUresult_o, full[31:0]);
        chk({tag, ".ctrl"}, {28'd0, bus.ctrl_o}, {28'd0, ctrl});
        chk({tag, ".wr"},   {27'd0, bus.WRaddr_o}, {27'd0, rd});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal;
    end

    initial begin
        logic [31:0] x, y;
        logic [5:0] fn;
        set_instr(4'd0, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0,
                  2'b00, 2'b00, 32'd0, 32'd0);
        #3;
        chk("rst.ctrl", {28'd0, bus.ctrl_o}, 32'd0);
        chk("rst.alu",  bus.ALUresult_o, 32'd0);
        chk("rst.wd",   bus.WriteData_o, 32'd0);
        chk("rst.wr",   {27'd0, bus.WRaddr_o}, 32'd0);
        chk("rst.stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rst.ovf",  {31'd0, bus.overflow_o}, 32'd0);
        #9 rst_n = 1'b1;
        tick();

        set_instr(4'b1010, 1'b0, 1'b1, 2'b10, 6'h20, 32'd5, 32'd7, 32'd0, 5'd3, 5'd9,
                  2'b00, 2'b00, 32'd0, 32'd0);
        run_alu("add57");
        chk("add57.lit", bus.ALUresult_o, 32'd12);

        set_instr(4'b1000, 1'b1, 1'b0, 2'b00, 6'd0, 32'h11, 32'h22, 32'd4, 5'd4, 5'd8,
                  2'b10, 2'b00, 32'h100, 32'h55);
        run_alu("fwdA");
        chk("fwdA.lit", bus.ALUresult_o, 32'h104);

        set_instr(4'b0010, 1'b0, 1'b0, 2'b00, 6'd0, 32'd1, 32'h33, 32'd4, 5'd6, 5'd8,
                  2'b00, 2'b01, 32'd0, 32'hAA);
        run_alu("fwdB");
        chk("fwdB.lit", bus.WriteData_o, 32'hAA);

        do_mul("mul6x7", 32'd6, 32'd7, 4'b1000, 5'd12, 1'b0);
        chk("mul6x7.lit", bus.ALUresult_o, 32'd42);
        set_instr(4'b1000, 1'b0, 1'b1, 2'b10, 6'h20, 32'd1, 32'd2, 32'd0, 5'd2, 5'd13,
                  2'b00, 2'b00, 32'd0, 32'd0);
        run_alu("after_mul");

        do_mul("mulmax", 32'hFFFFFFFF, 32'd2, 4'b1100, 5'd14, 1'b1);
        chk("mulmax.lit", bus.ALUresult_o, 32'hFFFFFFFE);

        // Flush during BUSY: stall drops at once, product never written.
        set_instr(4'b1000, 1'b0, 1'b1, 2'b10, 6'h18, 32'd3, 32'd5, 32'd0, 5'd1, 5'd7,
                  2'b00, 2'b00, 32'd0, 32'd0);
        #1;
        for (int i = 0; i < 5; i++) tick();
        chk("flush.pre", {31'd0, bus.stall_o}, 32'd1);
        bus.flush_i = 1'b1;
        #1 chk("flush.stall", {31'd0, bus.stall_o}, 32'd0);
        tick();
        chk("flush.ctrl", {28'd0, bus.ctrl_o}, 32'd0);
        chk("flush.ovf", {31'd0, bus.overflow_o}, 32'd0);
        for (int i = 0; i < MUL_CYC + 4; i++) begin
            set_instr(4'd0, 1'b0, 1'b0, 2'b00, 6'd0, $urandom_range(0, 999), 32'd1, 32'd0,
                      5'd5, 5'd6, 2'b00, 2'b00, 32'd0, 32'd0);
            run_alu("postflush");
        end

        // Flush together with a new mul in IDLE: nothing starts.
        set_instr(4'b1000, 1'b0, 1'b1, 2'b10, 6'h18, 32'd3, 32'd5, 32'd0, 5'd1, 5'd7,
                  2'b00, 2'b00, 32'd0, 32'd0);
        bus.flush_i = 1'b1;
        #1 chk("flushidle.stall", {31'd0, bus.stall_o}, 32'd0);
        tick();
        chk("flushidle.ctrl", {28'd0, bus.ctrl_o}, 32'd0);
        set_instr(4'b1000, 1'b0, 1'b1, 2'b10, 6'h20, 32'd2, 32'd2, 32'd0, 5'd1, 5'd7,
                  2'b00, 2'b00, 32'd0, 32'd0);
        run_alu("flushidle.next");

        // Asynchronous reset in the middle of a multiply.
        set_instr(4'b1000, 1'b0, 1'b1, 2'b10, 6'h18, 32'd9, 32'd9, 32'd0, 5'd1, 5'd11,
                  2'b00, 2'b00, 32'd0, 32'd0);
        #1;
        for (int i = 0; i < 6; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.ctrl", {28'd0, bus.ctrl_o}, 32'd0);
        chk("arst.alu",  bus.ALUresult_o, 32'd0);
        chk("arst.wd",   bus.WriteData_o, 32'd0);
        chk("arst.wr",   {27'd0, bus.WRaddr_o}, 32'd0);
        chk("arst.stall", {31'd0, bus.stall_o}, 32'd0);
        chk("arst.ovf",  {31'd0, bus.overflow_o}, 32'd0);
        set_instr(4'b1000, 1'b0, 1'b1, 2'b10, 6'h20, 32'd1, 32'd1, 32'd0, 5'd1, 5'd3,
                  2'b00, 2'b00, 32'd0, 32'd0);
        #3 rst_n = 1'b1;
        run_alu("arst.add");
        chk("arst.add.lit", bus.ALUresult_o, 32'd2);

        // Signed overflow boundaries.
        set_instr(4'b1000, 1'b0, 1'b0, 2'b00, 6'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 5'd4, 5'd5,
                  2'b00, 2'b00, 32'd0, 32'd0);
        run_alu("ovfadd");
        chk("ovfadd.lit", bus.ALUresult_o, 32'h80000000);
`ifdef EX_OVERFLOW_TRAP_EN
        chk("ovfadd.flag", {31'd0, bus.overflow_o}, 32'd1);
        chk("ovfadd.rw", {31'd0, bus.ctrl_o[3]}, 32'd0);
`else
        chk("ovfadd.flag", {31'd0, bus.overflow_o}, 32'd0);
        chk("ovfadd.rw", {31'd0, bus.ctrl_o[3]}, 32'd1);
`endif
        set_instr(4'b1000, 1'b0, 1'b1, 2'b10, 6'h22, 32'h80000000, 32'd1, 32'd0, 5'd4, 5'd5,
                  2'b00, 2'b00, 32'd0, 32'd0);
        run_alu("ovfsub");
        chk("ovfsub.lit", bus.ALUresult_o, 32'h7FFFFFFF);

        // Randomized non-mul traffic.
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                3: fn = 6'h25; 4: fn = 6'h2A;
                default: begin
                    fn = 6'($urandom_range(0, 63));
                    if (fn == 6'h18) fn = 6'h00;
                end
            endcase
            set_instr(4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), fn, x, y,
                      $urandom, 5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
                      $urandom, $urandom);
            run_alu("rand");
        end

        for (int i = 0; i < 3; i++)
            do_mul("randmul", $urandom, $urandom, 4'($urandom), 5'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
